led_row_scanner: RTL



---
 rtl/led_matrix_pkg.sv | 18 +
 rtl/led_frame_buffer.sv | 49 ++++
 rtl/led_row_scanner.sv | 130 +++++++++++++
 3 files changed

// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED matrix scan path and its prescaler top.
package led_matrix_pkg;

    localparam int LED_ROWS   = 8;
    localparam int LED_COLS   = 8;
    localparam int ONEHOT_MAX = 32;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    // Callers cast the result down to their own row count (<= ONEHOT_MAX).
    function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx);
        return ONEHOT_MAX'(1) << idx;
    endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// Double-buffered frame store: host writes the back bank, scanner reads the front bank.
module led_frame_buffer
    import led_matrix_pkg::*;
#(
    parameter int ROWS = LED_ROWS,
    parameter int COLS = LED_COLS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    swap,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    output logic [COLS-1:0]         rd_data
);

    logic [COLS-1:0] bank0 [ROWS];
    logic [COLS-1:0] bank1 [ROWS];
    logic            front_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_sel <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else begin
            if (swap) begin
                front_sel <= ~front_sel;
            end
            if (wr_en) begin
                if (front_sel) begin
                    bank0[wr_row] <= wr_data;
                end else begin
                    bank1[wr_row] <= wr_data;
                end
            end
        end
    end

    // Read through the post-swap select so the row latched on the swap edge
    // already comes from the new front bank.
    always_comb begin
        rd_data = (front_sel ^ swap) ? bank1[rd_row] : bank0[rd_row];
    end

endmodule

// File: rtl/led_row_scanner.sv
// Row-multiplexed LED matrix driver with blanking between rows and
// frame-aligned buffer swap on commit.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_BLANK | all rows/columns off; after BLANK_TICKS advance to next row
//   ST_DRIVE | one row driven with its latched column data for ON_TICKS
module led_row_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROWS        = LED_ROWS,
    parameter int COLS        = LED_COLS,
    parameter int ON_TICKS    = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    commit,
    output logic                    commit_pending,
    output logic [ROWS-1:0]         row_sel,
    output logic [COLS-1:0]         col_data,
    output logic                    frame_start
);

    localparam int RW   = $clog2(ROWS);
    localparam int MAXT = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int CW   = $clog2(MAXT + 1);

    localparam logic [CW-1:0] ON_LAST    = CW'(ON_TICKS - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    scan_state_t     state;
    logic [CW-1:0]   tick_cnt;
    logic [RW-1:0]   row;
    logic [RW-1:0]   next_row;
    logic            row_enter;
    logic            do_swap;
    logic            row_ok;
    logic            wr_en;
    logic            pending_nxt;
    logic [COLS-1:0] rd_data;

    assign next_row  = (row == ROW_LAST) ? '0 : row + 1'b1;
    assign row_enter = tick && (state == ST_BLANK) && (tick_cnt == BLANK_LAST);
    assign do_swap   = row_enter && (next_row == '0) && commit_pending;

    // Out-of-range row addresses are only possible when ROWS is not a power of two.
    generate
        if ((1 << RW) > ROWS) begin : g_row_chk
            assign row_ok = (wr_row <= ROW_LAST);
        end else begin : g_row_all
            assign row_ok = 1'b1;
        end
    endgenerate

    assign wr_en = wr_valid && wr_ready && row_ok;

    always_comb begin
        pending_nxt = commit_pending;
        if (do_swap) begin
            pending_nxt = 1'b0;
        end else if (commit) begin
            pending_nxt = 1'b1;
        end
    end

    led_frame_buffer #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_frame_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .swap    (do_swap),
        .rd_row  (next_row),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_BLANK;
            tick_cnt       <= '0;
            row            <= ROW_LAST;
            commit_pending <= 1'b0;
            wr_ready       <= 1'b1;
            row_sel        <= '0;
            col_data       <= '0;
            frame_start    <= 1'b0;
        end else begin
            commit_pending <= pending_nxt;
            wr_ready       <= !pending_nxt;
            frame_start    <= 1'b0;
            if (tick) begin
                case (state)
                    ST_DRIVE: begin
                        if (tick_cnt == ON_LAST) begin
                            state    <= ST_BLANK;
                            tick_cnt <= '0;
                            row_sel  <= '0;
                            col_data <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    ST_BLANK: begin
                        if (tick_cnt == BLANK_LAST) begin
                            state       <= ST_DRIVE;
                            tick_cnt    <= '0;
                            row         <= next_row;
                            row_sel     <= ROWS'(onehot(32'(next_row)));
                            col_data    <= rd_data;
                            frame_start <= (next_row == '0);
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
